// File: rtl/orv64_hpm_cntr_bank.sv
// ---------------------------------------------------------------------------
// orv64_hpm_cntr_bank
//
// Bank of N_CNTR hardware performance-monitor counters for the ORV64 core.
// Each counter is CNTR_WIDTH bits wide. At run time it is pointed at one of
// N_EVENT event lines. Every counter has its own inhibit bit, sticky overflow
// flag and overflow-interrupt enable. The CSR unit reaches the bank through a
// registered request/response port with a fixed one-cycle read latency and
// no backpressure.
//
// Ports
//   clk         core clock
//   rst         asynchronous active-high reset
//   event_i     one-cycle event pulses, bit e = event e occurred this cycle
//   freeze_i    global count halt (debug); CSR access keeps working
//   csr_req     access request, one cycle
//   csr_we      1 = write, 0 = read (qualified by csr_req)
//   csr_sel     0 = counter value, 1 = event select, 2 = control, 3 = reserved
//   csr_idx     counter index
//   csr_wdata   write data
//   csr_rvalid  read response valid, one cycle after a read request
//   csr_rdata   read data, zero whenever csr_rvalid is low
//   csr_err     bad-address flag, one cycle after the offending request
//   ovf_irq_o   level interrupt: OR over counters of (ovf & irq_en)
//
// Control register layout (sel = 2):
//   bit0 inhibit (RW), bit1 irq_en (RW), bit2 ovf (RO, write 1 to clear)
// ---------------------------------------------------------------------------
module orv64_hpm_cntr_bank #(
    parameter int N_CNTR        = 8,
    parameter int CNTR_WIDTH    = 48,
    parameter int N_EVENT       = 32,
    parameter int EVT_SEL_WIDTH = (N_EVENT > 1) ? $clog2(N_EVENT) : 1,
    parameter int IDX_WIDTH     = (N_CNTR > 1) ? $clog2(N_CNTR) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_EVENT-1:0] event_i,
    input  logic               freeze_i,
    input  logic               csr_req,
    input  logic               csr_we,
    input  logic [1:0]         csr_sel,
    input  logic [4:0]         csr_idx,
    input  logic [63:0]        csr_wdata,
    output logic               csr_rvalid,
    output logic [63:0]        csr_rdata,
    output logic               csr_err,
    output logic               ovf_irq_o
);

    // An event-select field that exactly spans the event lines can never
    // point past them, so the range check is only built when it can matter.
    localparam bit EVT_SEL_FULL = (N_EVENT == (1 << EVT_SEL_WIDTH));

    // A 5-bit index can never exceed a 32-entry bank.
    localparam bit IDX_FULL = (N_CNTR >= 32);

    localparam logic [1:0] SEL_CNTR = 2'd0;
    localparam logic [1:0] SEL_EVT  = 2'd1;
    localparam logic [1:0] SEL_CTRL = 2'd2;
    localparam logic [1:0] SEL_RSVD = 2'd3;

    // Architectural state
    logic [CNTR_WIDTH-1:0]    cntr_q   [N_CNTR];
    logic [EVT_SEL_WIDTH-1:0] evtsel_q [N_CNTR];
    logic [N_CNTR-1:0]        inhibit_q;
    logic [N_CNTR-1:0]        irq_en_q;
    logic [N_CNTR-1:0]        ovf_q;

    // Address decode
    logic                 idx_ok;
    logic                 addr_ok;
    logic [IDX_WIDTH-1:0] idx;
    logic                 wr_en;
    logic                 rd_en;

    // Per-counter control strobes
    logic [N_CNTR-1:0] hit;
    logic [N_CNTR-1:0] inc;
    logic [N_CNTR-1:0] wrap;
    logic [N_CNTR-1:0] wr_cntr;
    logic [N_CNTR-1:0] wr_evt;
    logic [N_CNTR-1:0] wr_ctrl;

    logic [63:0] rd_mux;

    // Only the low CNTR_WIDTH / EVT_SEL_WIDTH / 3 bits of the write data are
    // meaningful; the rest is deliberately dropped.
    logic unused_wdata;
    assign unused_wdata = ^csr_wdata;

    generate
        if (IDX_FULL) begin : g_idx_full
            assign idx_ok = 1'b1;
        end else begin : g_idx_part
            assign idx_ok = (32'(csr_idx) < N_CNTR);
        end
    endgenerate

    assign idx     = csr_idx[IDX_WIDTH-1:0];
    assign addr_ok = idx_ok && (csr_sel != SEL_RSVD);
    assign wr_en   = csr_req && csr_we && addr_ok;
    assign rd_en   = csr_req && !csr_we;

    // Per-counter strobes. The increment is decided from the registered
    // inhibit, so a control write that sets inhibit still lets an event in
    // the same cycle count. A counter write overrides the increment, and an
    // increment lost that way cannot raise the overflow flag.
    generate
        for (genvar g = 0; g < N_CNTR; g++) begin : g_cntr
            if (EVT_SEL_FULL) begin : g_sel_full
                assign hit[g] = event_i[evtsel_q[g]];
            end else begin : g_sel_part
                assign hit[g] = (32'(evtsel_q[g]) < N_EVENT) && event_i[evtsel_q[g]];
            end

            assign wr_cntr[g] = wr_en && (csr_sel == SEL_CNTR) && (idx == IDX_WIDTH'(g));
            assign wr_evt[g]  = wr_en && (csr_sel == SEL_EVT)  && (idx == IDX_WIDTH'(g));
            assign wr_ctrl[g] = wr_en && (csr_sel == SEL_CTRL) && (idx == IDX_WIDTH'(g));

            assign inc[g]  = hit[g] && !inhibit_q[g] && !freeze_i;
            assign wrap[g] = inc[g] && !wr_cntr[g] && (&cntr_q[g]);
        end
    endgenerate

    // Counter, event-select and control state. The overflow set from a wrap
    // is applied after the write-1-to-clear so that a simultaneous clear and
    // wrap leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CNTR; i++) begin
                cntr_q[i]   <= '0;
                evtsel_q[i] <= '0;
            end
            inhibit_q <= '1;
            irq_en_q  <= '0;
            ovf_q     <= '0;
        end else begin
            for (int i = 0; i < N_CNTR; i++) begin
                if (wr_cntr[i]) begin
                    cntr_q[i] <= csr_wdata[CNTR_WIDTH-1:0];
                end else if (inc[i]) begin
                    cntr_q[i] <= cntr_q[i] + CNTR_WIDTH'(1);
                end

                if (wr_evt[i]) begin
                    evtsel_q[i] <= csr_wdata[EVT_SEL_WIDTH-1:0];
                end

                if (wr_ctrl[i]) begin
                    inhibit_q[i] <= csr_wdata[0];
                    irq_en_q[i]  <= csr_wdata[1];
                end

                if (wrap[i]) begin
                    ovf_q[i] <= 1'b1;
                end else if (wr_ctrl[i] && csr_wdata[2]) begin
                    ovf_q[i] <= 1'b0;
                end
            end
        end
    end

    // Read mux over the pre-edge state, so the response shows the register
    // as it stood when the request was sampled. Bad addresses read as zero.
    always_comb begin
        rd_mux = '0;
        if (addr_ok) begin
            case (csr_sel)
                SEL_CNTR: rd_mux[CNTR_WIDTH-1:0]    = cntr_q[idx];
                SEL_EVT:  rd_mux[EVT_SEL_WIDTH-1:0] = evtsel_q[idx];
                SEL_CTRL: rd_mux[2:0]               = {ovf_q[idx], irq_en_q[idx], inhibit_q[idx]};
                default:  rd_mux                    = '0;
            endcase
        end
    end

    // Registered response and interrupt. Reset drops any response that was
    // in flight. The interrupt follows ovf/irq_en with one cycle of delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_rvalid <= 1'b0;
            csr_rdata  <= '0;
            csr_err    <= 1'b0;
            ovf_irq_o  <= 1'b0;
        end else begin
            csr_rvalid <= rd_en;
            csr_rdata  <= rd_en ? rd_mux : '0;
            csr_err    <= csr_req && !addr_ok;
            ovf_irq_o  <= |(ovf_q & irq_en_q);
        end
    end

endmodule

// File: tb/tb_orv64_hpm_cntr_bank.sv
// ---------------------------------------------------------------------------
// tb_orv64_hpm_cntr_bank
//
// Self-checking bench for orv64_hpm_cntr_bank with the default parameters
// (8 counters, 48-bit, 32 events). A behavioural model holds the counter
// bank as plain integers. It advances once per clock and predicts every
// output after every edge. Directed scenarios come first, then a random
// phase, then a reset taken while a read response is in flight.
// ---------------------------------------------------------------------------
module tb_orv64_hpm_cntr_bank;

    localparam int NC = 8;
    localparam longint unsigned MASK = 64'h0000_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] event_i;
    logic        freeze_i;
    logic        csr_req;
    logic        csr_we;
    logic [1:0]  csr_sel;
    logic [4:0]  csr_idx;
    logic [63:0] csr_wdata;
    logic        csr_rvalid;
    logic [63:0] csr_rdata;
    logic        csr_err;
    logic        ovf_irq_o;

    // Reference model state
    longint unsigned m_cnt [NC];
    int              m_sel [NC];
    bit              m_inh [NC];
    bit              m_ien [NC];
    bit              m_ovf [NC];

    bit              exp_rvalid;
    bit              exp_err;
    bit              exp_irq;
    longint unsigned exp_rdata;

    int errors = 0;
    int checks = 0;

    orv64_hpm_cntr_bank #(
        .N_CNTR    (NC),
        .CNTR_WIDTH(48),
        .N_EVENT   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .event_i   (event_i),
        .freeze_i  (freeze_i),
        .csr_req   (csr_req),
        .csr_we    (csr_we),
        .csr_sel   (csr_sel),
        .csr_idx   (csr_idx),
        .csr_wdata (csr_wdata),
        .csr_rvalid(csr_rvalid),
        .csr_rdata (csr_rdata),
        .csr_err   (csr_err),
        .ovf_irq_o (ovf_irq_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0;
            m_sel[i] = 0;
            m_inh[i] = 1'b1;
            m_ien[i] = 1'b0;
            m_ovf[i] = 1'b0;
        end
    endtask

    // Predict the outputs after the coming edge from the current state and
    // inputs, then move the model state across that edge.
    task automatic modelEdge();
        bit ok;
        bit counts;
        bit wrapped;
        bit wr;
        int k;
        longint unsigned rd;

        k  = int'(csr_idx);
        ok = (k < NC) && (csr_sel != 2'd3);
        rd = 0;

        exp_irq = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (m_ovf[i] && m_ien[i]) exp_irq = 1'b1;
        end

        exp_rvalid = csr_req && !csr_we;
        exp_err    = csr_req && !ok;
        if (exp_rvalid && ok) begin
            case (csr_sel)
                2'd0:    rd = m_cnt[k];
                2'd1:    rd = longint'(m_sel[k]);
                2'd2:    rd = (m_inh[k] ? 1 : 0) + (m_ien[k] ? 2 : 0) + (m_ovf[k] ? 4 : 0);
                default: rd = 0;
            endcase
        end
        exp_rdata = rd;

        for (int i = 0; i < NC; i++) begin
            counts  = (m_sel[i] < 32) && event_i[m_sel[i]] && !m_inh[i] && !freeze_i;
            wrapped = 1'b0;
            wr      = csr_req && csr_we && ok && (k == i);

            if (wr && csr_sel == 2'd0) begin
                m_cnt[i] = csr_wdata & MASK;
            end else if (counts) begin
                if (m_cnt[i] == MASK) begin
                    m_cnt[i] = 0;
                    wrapped  = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end

            if (wr && csr_sel == 2'd1) m_sel[i] = int'(csr_wdata[4:0]);

            if (wr && csr_sel == 2'd2) begin
                m_inh[i] = csr_wdata[0];
                m_ien[i] = csr_wdata[1];
                if (csr_wdata[2]) m_ovf[i] = 1'b0;
            end

            if (wrapped) m_ovf[i] = 1'b1;
        end
    endtask

    // One clock with the currently driven inputs, checked against the model.
    task automatic applyStimulus();
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput("rvalid", csr_rvalid, exp_rvalid);
        checkOutput("rdata",  csr_rdata,  exp_rdata);
        checkOutput("err",    csr_err,    exp_err);
        checkOutput("irq",    ovf_irq_o,  exp_irq);
    endtask

    task automatic idleCycle();
        csr_req   = 1'b0;
        csr_we    = 1'b0;
        csr_sel   = 2'd0;
        csr_idx   = 5'd0;
        csr_wdata = '0;
        applyStimulus();
    endtask

    task automatic csrWrite(input logic [1:0] sel, input logic [4:0] idx, input logic [63:0] data);
        csr_req   = 1'b1;
        csr_we    = 1'b1;
        csr_sel   = sel;
        csr_idx   = idx;
        csr_wdata = data;
        applyStimulus();
        csr_req   = 1'b0;
        csr_we    = 1'b0;
    endtask

    task automatic csrRead(input logic [1:0] sel, input logic [4:0] idx, input logic [63:0] want, input string tag);
        csr_req   = 1'b1;
        csr_we    = 1'b0;
        csr_sel   = sel;
        csr_idx   = idx;
        csr_wdata = '0;
        applyStimulus();
        checkOutput(tag, csr_rdata, want);
        csr_req   = 1'b0;
    endtask

    initial begin
        int r;

        rst       = 1'b1;
        event_i   = '0;
        freeze_i  = 1'b0;
        csr_req   = 1'b0;
        csr_we    = 1'b0;
        csr_sel   = 2'd0;
        csr_idx   = 5'd0;
        csr_wdata = '0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rvalid", csr_rvalid, 0);
        checkOutput("reset_rdata",  csr_rdata,  0);
        checkOutput("reset_err",    csr_err,    0);
        checkOutput("reset_irq",    ovf_irq_o,  0);
        rst = 1'b0;

        $display("[TB] reset values");
        csrRead(2'd2, 5'd0, 64'h1, "t1_ctrl0");
        csrRead(2'd2, 5'd7, 64'h1, "t1_ctrl7");
        csrRead(2'd0, 5'd3, 64'h0, "t1_cntr3");

        $display("[TB] basic counting");
        csrWrite(2'd1, 5'd2, 64'd5);
        csrWrite(2'd2, 5'd2, 64'd0);
        event_i = 32'h1 << 5;
        repeat (10) idleCycle();
        event_i = '0;
        csrRead(2'd0, 5'd2, 64'd10, "t2_cntr2");
        csrRead(2'd0, 5'd0, 64'd0,  "t2_cntr0");
        csrRead(2'd0, 5'd5, 64'd0,  "t2_cntr5");

        $display("[TB] wrap and overflow interrupt");
        csrWrite(2'd0, 5'd1, MASK - 1);
        csrWrite(2'd1, 5'd1, 64'd0);
        csrWrite(2'd2, 5'd1, 64'h2);
        event_i = 32'h1;
        idleCycle();
        idleCycle();
        checkOutput("t3_irq_not_yet", ovf_irq_o, 0);
        idleCycle();
        checkOutput("t3_irq_rise", ovf_irq_o, 1);
        event_i = '0;
        csrRead(2'd0, 5'd1, 64'd1, "t3_cntr1");
        csrRead(2'd2, 5'd1, 64'h6, "t3_ctrl1");
        csrWrite(2'd2, 5'd1, 64'h6);
        idleCycle();
        checkOutput("t3_irq_fall", ovf_irq_o, 0);

        $display("[TB] simultaneous write and count");
        csrWrite(2'd2, 5'd0, 64'd0);
        event_i = 32'h1;
        csrWrite(2'd0, 5'd0, 64'd100);
        event_i = '0;
        csrRead(2'd0, 5'd0, 64'd100, "t4_write_wins");
        csrWrite(2'd0, 5'd1, MASK);
        csrRead(2'd2, 5'd1, 64'h2, "t4_ovf_clear_before");
        event_i = 32'h1;
        csrWrite(2'd2, 5'd1, 64'h6);
        event_i = '0;
        csrRead(2'd2, 5'd1, 64'h6, "t4_set_wins");
        csrRead(2'd0, 5'd1, 64'd0, "t4_cntr1_wrapped");

        $display("[TB] freeze");
        freeze_i = 1'b1;
        event_i  = '1;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) csrWrite(2'd0, 5'd4, 64'd7);
            else idleCycle();
        end
        freeze_i = 1'b0;
        event_i  = '0;
        csrRead(2'd0, 5'd4, 64'd7,   "t5_cntr4");
        csrRead(2'd0, 5'd0, 64'd101, "t5_cntr0");
        csrRead(2'd0, 5'd2, 64'd10,  "t5_cntr2");
        csrRead(2'd0, 5'd1, 64'd0,   "t5_cntr1");

        $display("[TB] bad addresses");
        csrRead(2'd0, 5'd8, 64'd0, "t6_bad_idx_rdata");
        checkOutput("t6_bad_idx_err", csr_err, 1);
        csrRead(2'd3, 5'd0, 64'd0, "t6_rsvd_rdata");
        checkOutput("t6_rsvd_err", csr_err, 1);
        csrWrite(2'd1, 5'd9, 64'd3);
        checkOutput("t6_bad_wr_err", csr_err, 1);
        csrRead(2'd0, 5'd31, 64'd0, "t6_idx31_rdata");
        checkOutput("t6_idx31_err", csr_err, 1);

        $display("[TB] random phase");
        for (int c = 0; c < 800; c++) begin
            csr_req   = ($urandom_range(0, 2) != 0);
            csr_we    = 1'($urandom_range(0, 1));
            csr_sel   = 2'($urandom_range(0, 3));
            csr_idx   = 5'($urandom_range(0, 9));
            r         = int'($urandom_range(0, 3));
            csr_wdata = (r == 0) ? (64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3)))
                                 : {$urandom, $urandom};
            event_i   = $urandom;
            freeze_i  = ($urandom_range(0, 15) == 0);
            applyStimulus();
        end
        event_i  = '0;
        freeze_i = 1'b0;
        idleCycle();

        $display("[TB] reset with read in flight");
        csrWrite(2'd0, 5'd2, 64'd55);
        csr_req = 1'b1;
        csr_we  = 1'b0;
        csr_sel = 2'd0;
        csr_idx = 5'd2;
        @(posedge clk);
        #1;
        csr_req = 1'b0;
        rst     = 1'b1;
        #1;
        checkOutput("t6_rst_rvalid", csr_rvalid, 0);
        checkOutput("t6_rst_rdata",  csr_rdata,  0);
        @(posedge clk);
        #1;
        checkOutput("t6_rst_rvalid_held", csr_rvalid, 0);
        checkOutput("t6_rst_irq",         ovf_irq_o,  0);
        rst = 1'b0;
        modelReset();
        csrRead(2'd0, 5'd2, 64'd0, "t6_rst_cntr2");
        csrRead(2'd1, 5'd2, 64'd0, "t6_rst_sel2");
        csrRead(2'd2, 5'd1, 64'h1, "t6_rst_ctrl1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
